reg4_piso: RTL

REG4_PISO -- requirements
Module: reg4_piso

---
 rtl/reg4_piso_if.sv | 31 +++
 rtl/reg4_piso.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reg4_piso_if.sv
// Parallel-load / serial-out handshake bundle for reg4_piso.
// The master drives the word, load request and downstream ready; the slave returns the serial stream and status.
interface reg4_piso_if;
  logic [3:0] Din;
  logic       LD;
  logic       SRDY;
  logic       SO;
  logic       SV;
  logic       BUSY;
  logic       DONE;

  modport master (
    output Din,
    output LD,
    output SRDY,
    input  SO,
    input  SV,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  Din,
    input  LD,
    input  SRDY,
    output SO,
    output SV,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/reg4_piso.sv
// 4-bit parallel-in serial-out transmitter with a valid/ready handshake and a one-cycle DONE pulse.
// Define REG4_PISO_PARITY_EN to append an even-parity bit, which makes each frame 5 bits long.
module reg4_piso #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  reg4_piso_if.slave bus
);

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                so_q,    so_d;
  logic                sv_q,    sv_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
`ifdef REG4_PISO_PARITY_EN
  logic                par_q,   par_d;
`endif

  // Bit presented on SO while shifting: the end of the register nearest the wire.
  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  // Next-state: load in IDLE, advance only on a transfer (valid and ready both high).
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef REG4_PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.LD) begin
          shreg_d = bus.Din;
          cnt_d   = '0;
`ifdef REG4_PISO_PARITY_EN
          par_d   = ^bus.Din;
`endif
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.SRDY) begin
          shreg_d = shift_once(shreg_q);
          if (cnt_q == LAST_CNT) begin
`ifdef REG4_PISO_PARITY_EN
            state_d = ST_PAR;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef REG4_PISO_PARITY_EN
      ST_PAR: begin
        if (bus.SRDY) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops alongside it.
  always_comb begin
    so_d   = 1'b0;
    sv_d   = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    case (state_d)
      ST_SHIFT: begin
        sv_d = 1'b1;
        so_d = head_bit(shreg_d);
      end
`ifdef REG4_PISO_PARITY_EN
      ST_PAR: begin
        sv_d = 1'b1;
        so_d = par_d;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG4_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REG4_PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.SO   = so_q;
  assign bus.SV   = sv_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule
